// File: rtl/sseg_scan_display.sv
// Multiplexed N-digit seven-segment driver: sequential binary-to-BCD conversion,
// leading-zero blanking, overflow dashes, per-digit decimal points and PWM dimming.
module sseg_scan_display #(
    parameter int CLK_HZ         = 50_000_000,
    parameter int REFRESH_HZ     = 1000,
    parameter int DIGITS         = 4,
    parameter int DATA_W         = 14,
    parameter int BLANK_LZ       = 1,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int AN_ACTIVE_LOW  = 1
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic [DATA_W-1:0] data,
    input  logic [DIGITS-1:0] dp_mask,
    input  logic [3:0]        brightness,
    output logic [7:0]        sseg_a_to_dp,
    output logic [DIGITS-1:0] sseg_an,
    output logic              busy,
    output logic              ovf
);

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < n; i++) begin
            p = p * 64'd10;
        end
        return p;
    endfunction

    localparam int SLOT   = CLK_HZ / (REFRESH_HZ * DIGITS);
    localparam int SLOT_W = (SLOT > 1) ? $clog2(SLOT) : 1;
    localparam int DIG_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int DIG_N  = 1 << DIG_W;
    localparam int BCD_W  = 4 * DIGITS;
    localparam int ACC_W  = BCD_W + 4;
    localparam int CNT_W  = $clog2(DATA_W + 1);
    localparam logic [63:0]       POW10   = pow10(DIGITS);
    localparam logic [7:0]        SEG_INV = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
    localparam logic [DIGITS-1:0] AN_INV  = (AN_ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

    function automatic logic [ACC_W-1:0] dabble_adjust(input logic [ACC_W-1:0] acc);
        logic [ACC_W-1:0] r;
        r = acc;
        for (int k = 0; k < ACC_W / 4; k++) begin
            if (acc[4*k +: 4] >= 4'd5) begin
                r[4*k +: 4] = acc[4*k +: 4] + 4'd3;
            end else begin
                r[4*k +: 4] = acc[4*k +: 4];
            end
        end
        return r;
    endfunction

    // Active-high segments {a,b,c,d,e,f,g}
    function automatic logic [6:0] seg_font(input logic [3:0] nib);
        logic [6:0] f;
        case (nib)
            4'h0:    f = 7'b1111110;
            4'h1:    f = 7'b0110000;
            4'h2:    f = 7'b1101101;
            4'h3:    f = 7'b1111001;
            4'h4:    f = 7'b0110011;
            4'h5:    f = 7'b1011011;
            4'h6:    f = 7'b1011111;
            4'h7:    f = 7'b1110000;
            4'h8:    f = 7'b1111111;
            4'h9:    f = 7'b1111011;
            4'hA:    f = 7'b1110111;
            4'hB:    f = 7'b0011111;
            4'hC:    f = 7'b1001110;
            4'hD:    f = 7'b0111101;
            4'hE:    f = 7'b1001111;
            4'hF:    f = 7'b1000111;
            default: f = 7'b0000000;
        endcase
        return f;
    endfunction

    typedef enum logic [1:0] {ST_IDLE, ST_CONV, ST_LOAD} state_t;

    state_t             state_r, state_s;
    logic [DATA_W-1:0]  last_data_r, last_data_s;
    logic [DATA_W-1:0]  shift_r, shift_s;
    logic [ACC_W-1:0]   acc_r, acc_s, acc_adj_s;
    logic [CNT_W-1:0]   bit_cnt_r, bit_cnt_s;
    logic [BCD_W-1:0]   disp_r, disp_s;
    logic               ovf_r, ovf_s;
    logic               busy_r;
    logic [SLOT_W-1:0]  slot_cnt_r;
    logic [DIG_W-1:0]   digit_r;
    logic [7:0]         seg_r, pat_s;
    logic [DIGITS-1:0]  an_r, an_s;
    logic [31:0]        on_time_s;
    logic [3:0]         nib_a [DIG_N];
    logic [DIG_N-1:0]   dp_a, blank_a, sel_s;

    assign acc_adj_s = dabble_adjust(acc_r);

    // Converter next-state and datapath
    always_comb begin
        state_s     = state_r;
        last_data_s = last_data_r;
        shift_s     = shift_r;
        acc_s       = acc_r;
        bit_cnt_s   = bit_cnt_r;
        disp_s      = disp_r;
        ovf_s       = ovf_r;
        case (state_r)
            ST_IDLE: begin
                if (data != last_data_r) begin
                    last_data_s = data;
                    shift_s     = data;
                    acc_s       = '0;
                    bit_cnt_s   = '0;
                    state_s     = ST_CONV;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_CONV: begin
                acc_s     = {acc_adj_s[ACC_W-2:0], shift_r[DATA_W-1]};
                shift_s   = shift_r << 1;
                bit_cnt_s = bit_cnt_r + CNT_W'(1);
                if (bit_cnt_r == CNT_W'(DATA_W - 1)) begin
                    state_s = ST_LOAD;
                end else begin
                    state_s = ST_CONV;
                end
            end
            ST_LOAD: begin
                disp_s  = acc_r[BCD_W-1:0];
                // Extra nibble catches carries; constant compare covers bits lost off the top
                ovf_s   = (acc_r[ACC_W-1 -: 4] != 4'd0) || (64'(last_data_r) >= POW10);
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Converter state register
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_r     <= ST_IDLE;
            last_data_r <= '0;
            shift_r     <= '0;
            acc_r       <= '0;
            bit_cnt_r   <= '0;
            disp_r      <= '0;
            ovf_r       <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            last_data_r <= last_data_s;
            shift_r     <= shift_s;
            acc_r       <= acc_s;
            bit_cnt_r   <= bit_cnt_s;
            disp_r      <= disp_s;
            ovf_r       <= ovf_s;
            busy_r      <= (state_s != ST_IDLE);
        end
    end

    // Slot and digit scan counters
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            slot_cnt_r <= '0;
            digit_r    <= '0;
        end else if (slot_cnt_r == SLOT_W'(SLOT - 1)) begin
            slot_cnt_r <= '0;
            if (digit_r == DIG_W'(DIGITS - 1)) begin
                digit_r <= '0;
            end else begin
                digit_r <= digit_r + DIG_W'(1);
            end
        end else begin
            slot_cnt_r <= slot_cnt_r + SLOT_W'(1);
        end
    end

    generate
        for (genvar k = 0; k < DIG_N; k++) begin : g_digit
            if (k < DIGITS) begin : g_real
                assign nib_a[k]   = disp_r[4*k +: 4];
                assign dp_a[k]    = dp_mask[k];
                assign blank_a[k] = (BLANK_LZ != 0) && (k > 0) && (disp_r[BCD_W-1:4*k] == '0);
            end else begin : g_pad
                assign nib_a[k]   = 4'd0;
                assign dp_a[k]    = 1'b0;
                assign blank_a[k] = 1'b1;
            end
            assign sel_s[k] = (digit_r == DIG_W'(k));
        end
    endgenerate

    assign on_time_s = ((32'(brightness) + 32'd1) * 32'(SLOT)) >> 4;

    // Active-high segment pattern and anode select for the current digit
    always_comb begin
        pat_s = 8'h00;
        an_s  = '0;
        if (ovf_r) begin
            pat_s = {7'b0000001, dp_a[digit_r]};
        end else if (blank_a[digit_r]) begin
            pat_s = {7'b0000000, dp_a[digit_r]};
        end else begin
            pat_s = {seg_font(nib_a[digit_r]), dp_a[digit_r]};
        end
        if (32'(slot_cnt_r) < on_time_s) begin
            an_s = sel_s[DIGITS-1:0];
        end else begin
            an_s = '0;
        end
    end

    // Output register applies pin polarity
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            seg_r <= SEG_INV;
            an_r  <= AN_INV;
        end else begin
            seg_r <= pat_s ^ SEG_INV;
            an_r  <= an_s ^ AN_INV;
        end
    end

    assign sseg_a_to_dp = seg_r;
    assign sseg_an      = an_r;
    assign busy         = busy_r;
    assign ovf          = ovf_r;

endmodule

// File: tb/tb_sseg_scan_display.sv
// Randomised bench for sseg_scan_display: a timeline model of conversion and scan
// is checked every cycle, plus hand-computed pins for the listed scenarios.
module tb_sseg_scan_display;

    localparam int DIGITS = 4;
    localparam int DATA_W = 14;
    localparam int SLOT   = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [13:0] data = 14'd0;
    logic [3:0]  dp_mask = 4'd0;
    logic [3:0]  brightness = 4'd15;
    logic [7:0]  seg_a, seg_b;
    logic [3:0]  an_a, an_b;
    logic        busy_a, busy_b, ovf_a, ovf_b;

    int tests = 0;
    int fails = 0;

    sseg_scan_display #(.CLK_HZ(6400), .REFRESH_HZ(100), .DIGITS(4), .DATA_W(14),
        .BLANK_LZ(1), .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)) dut_a (
        .sys_clk(clk), .sys_rst_n(rst_n), .data(data), .dp_mask(dp_mask),
        .brightness(brightness), .sseg_a_to_dp(seg_a), .sseg_an(an_a),
        .busy(busy_a), .ovf(ovf_a));

    sseg_scan_display #(.CLK_HZ(6400), .REFRESH_HZ(100), .DIGITS(4), .DATA_W(14),
        .BLANK_LZ(0), .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)) dut_b (
        .sys_clk(clk), .sys_rst_n(rst_n), .data(data), .dp_mask(dp_mask),
        .brightness(brightness), .sseg_a_to_dp(seg_b), .sseg_an(an_b),
        .busy(busy_b), .ovf(ovf_b));

    initial forever #5 clk = ~clk;

    logic [6:0] font [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                              7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected active-low segment byte for decimal value val on digit dig
    function automatic logic [7:0] exp_seg(input int val, input bit ov, input int dig,
                                           input bit dp, input bit lz);
        int pw;
        logic [6:0] g;
        pw = 1;
        for (int i = 0; i < dig; i++) pw = pw * 10;
        if (ov) g = 7'b0000001;
        else if (lz && dig > 0 && val < pw) g = 7'b0000000;
        else g = font[(val / pw) % 10];
        return ~{g, dp};
    endfunction

    int e, last_m, disp_m, conv_val, idle_from, load_edge;
    bit ovf_m;
    bit x_valid = 1'b0;
    logic [3:0] x_an;
    logic [7:0] x_seg_a, x_seg_b;
    logic x_busy, x_ovf;

    // Model: edge e after release shows scan position e-1 and the display before edge e
    initial forever begin
        int p, slot, dig, on;
        @(posedge clk);
        if (!rst_n) begin
            e = 0; last_m = 0; disp_m = 0; ovf_m = 1'b0;
            idle_from = 1; load_edge = 0; conv_val = 0; x_valid = 1'b0;
        end else begin
            e++;
            p    = e - 1;
            slot = p % SLOT;
            dig  = (p / SLOT) % DIGITS;
            on   = ((int'(brightness) + 1) * SLOT) >> 4;
            x_an = (slot < on) ? ~(4'b0001 << dig) : 4'b1111;
            x_seg_a = exp_seg(disp_m, ovf_m, dig, dp_mask[dig], 1'b1);
            x_seg_b = exp_seg(disp_m, ovf_m, dig, dp_mask[dig], 1'b0);
            if (e >= idle_from) begin
                if (int'(data) != last_m) begin
                    last_m    = int'(data);
                    conv_val  = int'(data);
                    load_edge = e + DATA_W + 1;
                    idle_from = e + DATA_W + 2;
                    x_busy    = 1'b1;
                end else begin
                    x_busy = 1'b0;
                end
            end else if (e == load_edge) begin
                disp_m = conv_val;
                ovf_m  = (conv_val >= 10000);
                x_busy = 1'b0;
            end else begin
                x_busy = 1'b1;
            end
            x_ovf   = ovf_m;
            x_valid = 1'b1;
        end
    end

    // Compare every cycle on the falling edge
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            check("rst_an", an_a, 4'hF);
            check("rst_seg", seg_a, 8'hFF);
            check("rst_busy", busy_a, 1'b0);
            check("rst_ovf", ovf_a, 1'b0);
            check("rst_seg_b", seg_b, 8'hFF);
        end else if (x_valid) begin
            check("an", an_a, x_an);
            check("seg", seg_a, x_seg_a);
            check("busy", busy_a, x_busy);
            check("ovf", ovf_a, x_ovf);
            check("an_b", an_b, x_an);
            check("seg_b", seg_b, x_seg_b);
            check("busy_b", busy_b, x_busy);
            check("ovf_b", ovf_b, x_ovf);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_an(input logic [3:0] target, input string name);
        int k;
        k = 0;
        @(negedge clk);
        while (an_a !== target && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (k >= 200) begin
            tests++;
            fails++;
            $display("FAIL %s: anode %0h never seen, last %0h", name, target, an_a);
        end
    endtask

    task automatic count_low(input int bit_i, output int n);
        n = 0;
        repeat (64) begin
            @(negedge clk);
            if (an_a[bit_i] == 1'b0) n++;
        end
    endtask

    initial begin
        int n, bad;
        #2 rst_n = 1'b0;
        cyc(3);
        rst_n = 1'b0;
        cyc(1);
        rst_n = 1'b1;

        // 1234: busy width and digit contents
        data = 14'd1234;
        n = 0;
        repeat (40) begin
            @(negedge clk);
            if (busy_a) n++;
        end
        check("busy_width", n, 15);
        wait_an(4'b1110, "wait_d0");
        check("pin_1234_d0", seg_a, 8'b1001_1001);
        wait_an(4'b0111, "wait_d3");
        check("pin_1234_d3", seg_a, 8'b1001_1111);

        // zero: blanking on instance a, "0000" on instance b
        cyc(1);
        data = 14'd0;
        cyc(20);
        wait_an(4'b1110, "wait_z0");
        check("pin_zero_d0", seg_a, 8'b0000_0011);
        wait_an(4'b1101, "wait_z1");
        check("pin_zero_d1_blank", seg_a, 8'b1111_1111);
        check("pin_zero_d1_nolz", seg_b, 8'b0000_0011);

        // overflow then recovery
        cyc(1);
        data = 14'd10000;
        cyc(20);
        check("pin_ovf_set", ovf_a, 1'b1);
        wait_an(4'b1011, "wait_o2");
        check("pin_dash", seg_a, 8'b1111_1101);
        cyc(1);
        data = 14'd9999;
        cyc(20);
        check("pin_ovf_clr", ovf_a, 1'b0);
        wait_an(4'b0111, "wait_n3");
        check("pin_9999_d3", seg_a, 8'b0000_1001);

        // brightness duty and decimal point
        cyc(1);
        brightness = 4'd0;
        cyc(2);
        count_low(0, n);
        check("duty_b0", n, 1);
        cyc(1);
        brightness = 4'd7;
        cyc(2);
        count_low(2, n);
        check("duty_b7", n, 8);
        cyc(1);
        brightness = 4'd15;
        dp_mask = 4'b0100;
        cyc(2);
        n = 0;
        bad = 0;
        repeat (64) begin
            @(negedge clk);
            if (seg_a[0] == 1'b0) begin
                n++;
                if (an_a !== 4'b1011) bad++;
            end
        end
        check("dp_count", n, 16);
        check("dp_digit", bad, 0);

        // data change mid-conversion
        cyc(1);
        dp_mask = 4'b0000;
        data = 14'd1234;
        cyc(3);
        data = 14'd42;
        cyc(40);
        wait_an(4'b1101, "wait_m1");
        check("pin_42_d1", seg_a, 8'b1001_1001);
        wait_an(4'b1011, "wait_m2");
        check("pin_42_d2", seg_a, 8'b1111_1111);

        // reset during conversion
        cyc(1);
        data = 14'd5000;
        cyc(4);
        #2 rst_n = 1'b0;
        #1;
        check("arst_an", an_a, 4'hF);
        check("arst_seg", seg_a, 8'hFF);
        check("arst_busy", busy_a, 1'b0);
        data = 14'd77;
        cyc(2);
        rst_n = 1'b1;
        cyc(17);
        wait_an(4'b1110, "wait_r0");
        check("pin_77_d0", seg_a, 8'b0001_1111);
        wait_an(4'b1101, "wait_r1");
        check("pin_77_d1", seg_a, 8'b0001_1111);

        // random traffic under the model
        for (int i = 0; i < 150; i++) begin
            cyc(1);
            if ($urandom_range(0, 3) == 0) data = 14'($urandom_range(0, 99));
            else data = 14'($urandom_range(0, 16383));
            brightness = 4'($urandom);
            dp_mask = 4'($urandom);
            cyc($urandom_range(1, 40));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
